// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the MEM-stage data memory controller.
// The optional DMEM_BOUNDS_CHECK_EN build is handled in data_memory_ctrl.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned BYTE_BITS = 8;

  function automatic int unsigned dmem_bytes(input int unsigned data_width);
    return data_width / BYTE_BITS;
  endfunction

  function automatic int unsigned dmem_lane_bits(input int unsigned data_width);
    return $clog2(data_width / BYTE_BITS);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Purely combinational lane steering: store byte enables/data placement and
// load lane extraction with sign or zero extension (little-endian lanes).
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned BYTES      = dmem_bytes(DATA_WIDTH),
  localparam int unsigned LANE_BITS  = dmem_lane_bits(DATA_WIDTH)
) (
  input  size_e                  size_i,
  input  logic [LANE_BITS-1:0]   lane_i,
  input  logic                   unsigned_i,
  input  logic [DATA_WIDTH-1:0]  wdata_i,
  input  logic [DATA_WIDTH-1:0]  rword_i,
  output logic [BYTES-1:0]       wbe_o,
  output logic [DATA_WIDTH-1:0]  wdata_o,
  output logic [DATA_WIDTH-1:0]  rdata_o,
  output logic                   misal_o
);

  logic [LANE_BITS+2:0] sh;
  logic [7:0]           byte_sel;
  logic [15:0]          half_sel;

  always_comb begin
    sh       = {lane_i, 3'b000};
    byte_sel = 8'(rword_i >> sh);
    half_sel = 16'(rword_i >> sh);
    wdata_o  = wdata_i << sh;
    wbe_o    = '0;
    rdata_o  = '0;
    misal_o  = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        wbe_o   = BYTES'(1) << lane_i;
        rdata_o = unsigned_i ? DATA_WIDTH'(byte_sel)
                             : {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        misal_o = lane_i[0];
        wbe_o   = BYTES'(3) << lane_i;
        rdata_o = unsigned_i ? DATA_WIDTH'(half_sel)
                             : {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      end
      SZ_WORD: begin
        misal_o = |lane_i;
        wbe_o   = '1;
        rdata_o = rword_i;
      end
      default: misal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// MEM-stage data memory: base translation, sized loads/stores, registered
// single-cycle response and post-reset zero fill. Optional DMEM_BOUNDS_CHECK_EN.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           MEMORY_DEPTH = 1024,
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(32'h1001_0000)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   rsp_valid,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   rsp_err,
  output logic                   init_done
);

  localparam int unsigned BYTES     = dmem_bytes(DATA_WIDTH);
  localparam int unsigned LANE_BITS = dmem_lane_bits(DATA_WIDTH);
  localparam int unsigned WORD_BITS = $clog2(MEMORY_DEPTH);

  state_e                 state_q;
  logic [WORD_BITS-1:0]   cnt_q;
  logic                   ready_q;
  logic                   init_done_q;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic [DATA_WIDTH-1:0]  mem_q [MEMORY_DEPTH];

  logic [ADDR_WIDTH-1:0]  off;
  logic [LANE_BITS-1:0]   lane;
  logic [WORD_BITS-1:0]   word_idx;
  logic                   accept;
  logic                   oob;
  logic                   misal;
  logic                   err;
  logic                   wr_en;
  logic [DATA_WIDTH-1:0]  rword;
  logic [BYTES-1:0]       wbe;
  logic [DATA_WIDTH-1:0]  wdata_al;
  logic [DATA_WIDTH-1:0]  rdata_al;

  // Address translation; word index wraps modulo depth.
  always_comb begin
    off      = req_addr - BASE_ADDR;
    lane     = off[LANE_BITS-1:0];
    word_idx = WORD_BITS'(off >> LANE_BITS);
    rword    = mem_q[word_idx];
  end

`ifdef DMEM_BOUNDS_CHECK_EN
  assign oob = |off[ADDR_WIDTH-1:LANE_BITS+WORD_BITS];
`else
  assign oob = 1'b0;
`endif

  dmem_lane_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_align (
    .size_i     (size_e'(req_size)),
    .lane_i     (lane),
    .unsigned_i (req_unsigned),
    .wdata_i    (req_wdata),
    .rword_i    (rword),
    .wbe_o      (wbe),
    .wdata_o    (wdata_al),
    .rdata_o    (rdata_al),
    .misal_o    (misal)
  );

  always_comb begin
    accept      = req_valid && ready_q;
    err         = misal || oob;
    wr_en       = accept && req_write && !err;
    rsp_valid_d = accept;
    rsp_err_d   = accept && err;
    rsp_rdata_d = (accept && !req_write && !err) ? rdata_al : '0;
  end

  // Control FSM, fill counter and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + WORD_BITS'(1);
          if (cnt_q == WORD_BITS'(MEMORY_DEPTH - 1)) begin
            state_q     <= ST_RUN;
            ready_q     <= 1'b1;
            init_done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  // Array: zero fill during INIT, byte-enabled stores afterwards.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wbe[b]) mem_q[word_idx][b*8 +: 8] <= wdata_al[b*8 +: 8];
      end
    end
  end

  assign req_ready = ready_q;
  assign init_done = init_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: directed plan steps plus random
// traffic checked against a byte-array reference model.
module tb_data_memory_ctrl;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned NBYTE = DEPTH * 4;
  localparam logic [31:0] BASE  = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] last_rd;
  logic        last_err;
  byte unsigned mdl [NBYTE];

  data_memory_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .init_done    (init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NBYTE; i++) mdl[i] = 8'h00;
  endtask

  // Reference: compute the response and apply any store to the byte array.
  task automatic model_req(input bit wr, input bit [1:0] sz, input bit uns,
                           input bit [31:0] addr, input bit [31:0] wd,
                           output bit err, output bit [31:0] rd);
    bit [31:0] off;
    int        lane, widx, nb;
    bit [31:0] v;
    off  = addr - BASE;
    lane = int'(off % 4);
    widx = int'((off / 4) % DEPTH);
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err  = (sz == 2'd3) || (sz == 2'd1 && (lane % 2) != 0) || (sz == 2'd2 && lane != 0);
`ifdef DMEM_BOUNDS_CHECK_EN
    if (off >= NBYTE) err = 1'b1;
`endif
    rd = 32'h0;
    if (err) return;
    if (wr) begin
      for (int i = 0; i < nb; i++) mdl[widx*4 + lane + i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mdl[widx*4 + lane + i];
      if (!uns && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!uns && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
      rd = v;
    end
  endtask

  task automatic do_req(input bit wr, input bit [1:0] sz, input bit uns,
                        input bit [31:0] addr, input bit [31:0] wd, input string tag);
    bit        e_err;
    bit [31:0] e_rd;
    model_req(wr, sz, uns, addr, wd, e_err, e_rd);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz;
    req_unsigned = uns; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    last_rd  = rsp_rdata;
    last_err = rsp_err;
    chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_err"}, 32'(rsp_err), 32'(e_err));
    chk({tag, "_rd"},  rsp_rdata, e_rd);
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_vld"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_rd"},  rsp_rdata, 32'd0);
  endtask

  task automatic wait_init(input string tag);
    int cyc;
    cyc = 0;
    while (!req_ready && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_cycles"}, 32'(cyc), 32'(DEPTH));
    chk({tag, "_done"}, 32'(init_done), 32'd1);
    model_clear();
  endtask

  initial begin
    bit [31:0] a;
    bit [1:0]  sz;
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err",   32'(rsp_err), 32'd0);
    chk("rst_done",  32'(init_done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    wait_init("init1");

    // Plan 1-3
    do_req(1'b0, 2'd2, 1'b0, BASE, 32'h0, "t1_lw0");
    chk("t1_lit", last_rd, 32'h0000_0000);
    do_req(1'b1, 2'd2, 1'b0, BASE + 4, 32'hDEAD_BEEF, "t2_sw");
    do_req(1'b0, 2'd2, 1'b0, BASE + 4, 32'h0, "t2_lw");
    chk("t2_lw_lit", last_rd, 32'hDEAD_BEEF);
    do_req(1'b0, 2'd0, 1'b0, BASE + 7, 32'h0, "t2_lb");
    chk("t2_lb_lit", last_rd, 32'hFFFF_FFDE);
    do_req(1'b0, 2'd0, 1'b1, BASE + 4, 32'h0, "t2_lbu");
    chk("t2_lbu_lit", last_rd, 32'h0000_00EF);
    do_req(1'b1, 2'd1, 1'b0, BASE + 6, 32'h0000_1234, "t3_sh");
    do_req(1'b0, 2'd2, 1'b0, BASE + 4, 32'h0, "t3_lw");
    chk("t3_lw_lit", last_rd, 32'h1234_BEEF);
    do_req(1'b0, 2'd1, 1'b1, BASE + 6, 32'h0, "t3_lhu");
    chk("t3_lhu_lit", last_rd, 32'h0000_1234);
    idle("idle1");

    // Plan 4: misalignment
    do_req(1'b0, 2'd2, 1'b0, BASE + 2, 32'h0, "t4_lw_mis");
    chk("t4_lw_mis_lit", 32'(last_err), 32'd1);
    do_req(1'b1, 2'd1, 1'b0, BASE + 1, 32'hFFFF_FFFF, "t4_sh_mis");
    chk("t4_sh_mis_lit", 32'(last_err), 32'd1);
    do_req(1'b0, 2'd2, 1'b0, BASE, 32'h0, "t4_lw0");
    chk("t4_lw0_lit", last_rd, 32'h0000_0000);
    do_req(1'b0, 2'd3, 1'b0, BASE, 32'h0, "t4_ill");
    chk("t4_ill_lit", 32'(last_err), 32'd1);

    // Plan 5: offset 4096 wraps or faults depending on build
    do_req(1'b1, 2'd2, 1'b0, BASE + 32'h1000, 32'hA5A5_A5A5, "t5_sw");
    do_req(1'b0, 2'd2, 1'b0, BASE, 32'h0, "t5_lw0");
`ifdef DMEM_BOUNDS_CHECK_EN
    chk("t5_lw0_lit", last_rd, 32'h0000_0000);
`else
    chk("t5_lw0_lit", last_rd, 32'hA5A5_A5A5);
`endif
    do_req(1'b0, 2'd2, 1'b0, BASE - 4, 32'h0, "t5_below");
    idle("idle2");

    // Random pipelined traffic around a small window plus occasional far addresses
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom();
      else a = BASE + 32'($urandom_range(0, 63));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if (sz == 2'd2 && $urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
      if (sz == 2'd1 && $urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFE;
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom(), "rnd");
      if ($urandom_range(0, 9) == 0) idle("rnd_idle");
    end

    // Plan 6: reset with a load response pending
    do_req(1'b1, 2'd2, 1'b0, BASE + 8,  32'h1111_2222, "t6_sw1");
    do_req(1'b1, 2'd2, 1'b0, BASE + 12, 32'h3333_4444, "t6_sw2");
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = BASE + 8;
    @(posedge clk); #1;
    chk("t6_pending", 32'(rsp_valid), 32'd1);
    reset = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(rsp_valid), 32'd0);
    chk("t6_rst_rdata", rsp_rdata, 32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    chk("t6_rst_done",  32'(init_done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    wait_init("init2");
    do_req(1'b0, 2'd2, 1'b0, BASE + 8, 32'h0, "t6_lw8");
    chk("t6_lw8_lit", last_rd, 32'h0000_0000);
    do_req(1'b0, 2'd2, 1'b0, BASE + 12, 32'h0, "t6_lw12");
    chk("t6_lw12_lit", last_rd, 32'h0000_0000);
    idle("idle3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised data memory for the MIPS datapath. Successor to the flat word-wide data RAM.
- Adds byte, halfword and word loads/stores with sign/zero extension.
- Adds base-address translation, misalignment detection and a registered, handshaked response.
- Adds a post-reset zero-fill sequence.
- Sits in the MEM stage, between the ALU result/rt operand and the write-back mux.

Parameters:
DATA_WIDTH, 32, word width in bits; multiple of 8, minimum 32; BYTES = DATA_WIDTH/8.
MEMORY_DEPTH, 1024, number of words; power of two.
ADDR_WIDTH, 32, width of the byte address.
BASE_ADDR, 32'h1001_0000, byte address mapped to word 0.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
req_valid  input  1  request present this cycle.
req_ready  output  1  block accepts a request this cycle.
req_write  input  1  1 = store, 0 = load.
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
req_addr  input  ADDR_WIDTH  byte address.
req_wdata  input  DATA_WIDTH  store data, right-justified.
rsp_valid  output  1  response present, single-cycle pulse.
rsp_rdata  output  DATA_WIDTH  load result; 0 for stores and errors.
rsp_err  output  1  request rejected.
init_done  output  1  zero-fill complete.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0. The FSM enters INIT and the fill counter is cleared.
- FSM states are INIT and RUN.
  - INIT: writes 0 to word [cnt] each cycle, cnt = 0..MEMORY_DEPTH-1, and holds req_ready=0.
  - After writing the last word, the FSM moves to RUN. req_ready and init_done go high MEMORY_DEPTH cycles after reset release.
  - RUN: req_ready=1 constantly. The state is terminal until reset.
- A request is accepted when req_valid && req_ready. One request is accepted per cycle, fully pipelined.
- Address decode:
  - off = req_addr - BASE_ADDR, in ADDR_WIDTH modular arithmetic.
  - word = off[log2(BYTES) +: log2(MEMORY_DEPTH)], wrapping modulo depth.
  - lane = off[log2(BYTES)-1:0].
- Endianness is little-endian: lane 0 holds bits [7:0].
- Misalignment is flagged for: half with lane[0]=1, word with lane!=0, or size 11. A misaligned request writes nothing.
- Stores: only the addressed bytes are written, using per-byte enables at the acceptance edge. Unaddressed bytes are unchanged. There is no read-modify-write cycle.
- Loads: the array is read at the acceptance edge. The lane is extracted, then extended per req_unsigned.
- Response timing: exactly 1 cycle after acceptance, for loads and stores alike.
  - rsp_valid=1.
  - rsp_err = misaligned (plus the optional bounds error).
  - rsp_rdata = extended load data, or 0 for stores and errors.
- There is no response backpressure.
- A store followed by a load to the same word in the next cycle returns the new data.
- Idle cycles drive rsp_valid=0; rsp_rdata and rsp_err return to 0.
- Reset mid-operation: outputs clear immediately and any in-flight response is dropped. The FSM re-enters INIT and the whole array is re-zeroed.

Optional Feature:
DMEM_BOUNDS_CHECK_EN
- Defined: any off >= MEMORY_DEPTH*BYTES, including req_addr < BASE_ADDR via wrap-around, sets rsp_err=1, suppresses the write and returns rdata 0.
- Undefined: the word index wraps modulo MEMORY_DEPTH and no bounds error exists.

Decomposition:
- Package dmem_pkg holds:
  - the size enum: SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL;
  - the FSM state enum: ST_INIT, ST_RUN;
  - helper constants: BYTES and LANE_BITS derivation.
- One combinational sub-module, dmem_lane_align, is natural. It generates the store byte enables and shifted write data, plus the load lane extraction and extension.
- The FSM, counter, array and response registers live in the top module.

Test Plan:
1. Release reset, DEPTH=1024 -> req_ready=0 for 1024 cycles, then req_ready=init_done=1. A word load of 0x10010000 returns rsp_rdata=0x00000000 one cycle after acceptance.
2. Word store 0xDEADBEEF at 0x10010004, then a word load at the same address -> 0xDEADBEEF. A signed byte load of 0x10010007 -> 0xFFFFFFDE. An unsigned byte load of 0x10010004 -> 0x000000EF.
3. Following test 2, a halfword store of 0x00001234 at 0x10010006, then a word load of 0x10010004 -> 0x1234BEEF. An unsigned halfword load of 0x10010006 -> 0x00001234.
4. Word load at 0x10010002 -> rsp_err=1, rdata=0. A halfword store at 0x10010001 -> rsp_err=1, and a following word load of 0x10010000 is unchanged.
5. Word store 0xA5A5A5A5 at 0x10011000 (offset 4096):
   - Macro undefined: word 0 is written and a load of 0x10010000 returns 0xA5A5A5A5.
   - Macro defined: rsp_err=1 and word 0 stays 0.
6. Back-to-back stores, with reset asserted while a load response is pending -> rsp_valid=0 immediately, req_ready=0 and the 1024-cycle INIT restarts. Prior data then reads 0.
